route_demux: RTL
================

ROUTE_DEMUX -- requirements
Module: route_demux

Interface
REQ-001 Parameter: WIDTH, default 32, data path width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 flush  input  1  synchronous pipeline flush; discards all held data.
REQ-005 s_valid  input  1  upstream data valid.
REQ-006 s_ready  output  1  block accepts upstream data this cycle.
REQ-007 s_sel  input  1  destination select: 0 -> port 0, 1 -> port 1.
REQ-008 s_data  input  WIDTH  upstream data.
REQ-009 m0_valid / m1_valid  output  1  port 0 / port 1 output register holds data.
REQ-010 m0_ready / m1_ready  input  1  port 0 / port 1 downstream accepts data.
REQ-011 m0_data / m1_data  output  WIDTH  port 0 / port 1 registered data.

Function
REQ-012 The block SHALL route each accepted upstream word to exactly one output port, selected by s_sel sampled in the accept cycle.
REQ-013 Upstream transfer SHALL occur when s_valid && s_ready at a rising clk edge; downstream transfer on port N SHALL occur when mN_valid && mN_ready.
REQ-014 Each port SHALL have one output register with two states: EMPTY (mN_valid=0) and FULL (mN_valid=1).
REQ-015 Transitions per port: EMPTY -> FULL on accept targeting it; FULL -> EMPTY on downstream transfer with no new accept targeting it; FULL -> FULL (data replaced) on simultaneous downstream transfer and accept targeting it.
REQ-016 s_ready SHALL equal !flush && (!mS_valid || mS_ready), where S = s_sel (combinational on s_sel, flush, selected port state).
REQ-017 Latency SHALL be exactly one cycle: data accepted at edge k is visible on mN_data with mN_valid=1 after edge k.
REQ-018 Sustained throughput SHALL be one word per cycle to either port while its downstream holds mN_ready=1.
REQ-019 The non-selected port SHALL hold its state and data unchanged on an accept; both ports MAY be FULL simultaneously.
REQ-020 mN_data SHALL remain stable while mN_valid=1 and mN_ready=0.
REQ-021 s_valid without s_ready SHALL not alter any state; upstream may change s_sel/s_data while stalled.
REQ-022 flush=1 SHALL, at the next edge, set both ports EMPTY, force s_ready=0 that cycle, and take priority over any accept or downstream transfer.
REQ-023 mN_data value while mN_valid=0 is don't-care, but SHALL NOT produce X after reset.

Reset
REQ-024 rst_n=0 SHALL immediately (asynchronously) set m0_valid=0, m1_valid=0, m0_data=0, m1_data=0, and counters (if present) to 0.
REQ-025 s_ready SHALL be 0 while rst_n=0; reset assertion mid-transfer SHALL discard held data without emitting it.
REQ-026 Release of rst_n SHALL be followed by normal operation from the first subsequent clk edge.

Configuration
REQ-027 Macro ROUTE_DEMUX_CNT_EN, when defined, SHALL add outputs m0_count and m1_count (output, 16 bits each), counting downstream transfers per port.
REQ-028 With ROUTE_DEMUX_CNT_EN: counters increment by 1 per downstream transfer, saturate at 16'hFFFF, are cleared by reset, and are NOT cleared by flush.
REQ-029 Without ROUTE_DEMUX_CNT_EN: count ports and counter logic SHALL be absent; all other behaviour identical.

Verification
REQ-030 Reset: rst_n=0 mid-stream with m0 FULL -> m0_valid=0, m0_data=0 immediately, s_ready=0.
REQ-031 Routing: accept 32'hDEAD_BEEF with s_sel=1, m1_ready=1 -> next cycle m1_valid=1, m1_data=32'hDEAD_BEEF, m0_valid unchanged 0.
REQ-032 Backpressure: m0 FULL with 32'h1, m0_ready=0, s_sel=0, s_valid=1 -> s_ready=0, m0_data holds 32'h1; switch s_sel=1 -> s_ready=1, word lands on m1.
REQ-033 Throughput: 8 back-to-back words 0..7 to port 0 with m0_ready=1 -> 8 consecutive output cycles, data 0..7 in order, no bubbles.
REQ-034 Flush: both ports FULL, flush=1 with s_valid=1, m0_ready=1 -> both EMPTY next cycle, no accept, no m0 count increment beyond the flushed transfer rule.
REQ-035 Counter (ROUTE_DEMUX_CNT_EN): 65,537 transfers on port 1 -> m1_count=16'hFFFF, m0_count=0.

Source files
------------

// File: rtl/route_demux.sv
// One-input, two-output registered demultiplexer: each accepted word lands in the output slot chosen by s_sel.
// Optional build macro ROUTE_DEMUX_CNT_EN adds saturating per-port downstream transfer counters.
module route_demux #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             s_sel,
  input  logic [WIDTH-1:0] s_data,
  output logic             m0_valid,
  input  logic             m0_ready,
  output logic [WIDTH-1:0] m0_data,
  output logic             m1_valid,
  input  logic             m1_ready,
  output logic [WIDTH-1:0] m1_data,
  output logic [1:0]       dbg_state
`ifdef ROUTE_DEMUX_CNT_EN
  ,
  output logic [15:0]      m0_count,
  output logic [15:0]      m1_count
`endif
);

  // Handshake: a transfer happens on a rising edge where valid && ready; valid never waits on ready,
  // and a FULL slot keeps its data stable until its own ready is seen.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

  slot_state_e      state_q [2];
  slot_state_e      state_d [2];
  logic [WIDTH-1:0] data_q  [2];
  logic [1:0]       m_ready;
  logic [1:0]       take;
  logic [1:0]       pop;
  logic             sel_busy;
  logic             accept;

  assign m_ready = {m1_ready, m0_ready};

  // Only the selected slot gates s_ready; it may refill in the same cycle it drains.
  assign sel_busy = (state_q[s_sel] == FULL) && !m_ready[s_sel];
  assign s_ready  = rst_n && !flush && !sel_busy;
  assign accept   = s_valid && s_ready;

  always_comb begin
    take = '0;
    pop  = '0;
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      take[i]    = accept && (s_sel == i[0]);
      pop[i]     = (state_q[i] == FULL) && m_ready[i] && !flush;
      if (flush) begin
        state_d[i] = EMPTY;
      end else if (take[i]) begin
        state_d[i] = FULL;
      end else if (pop[i]) begin
        state_d[i] = EMPTY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= EMPTY;
        data_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        if (take[i]) begin
          data_q[i] <= s_data;
        end
      end
    end
  end

  assign m0_valid  = (state_q[0] == FULL);
  assign m1_valid  = (state_q[1] == FULL);
  assign m0_data   = data_q[0];
  assign m1_data   = data_q[1];
  assign dbg_state = {state_q[1] == FULL, state_q[0] == FULL};

`ifdef ROUTE_DEMUX_CNT_EN
  // Counters survive flush; a handshake coinciding with flush is discarded and not counted.
  logic [15:0] cnt_q [2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (pop[i] && (cnt_q[i] != 16'hFFFF)) begin
          cnt_q[i] <= cnt_q[i] + 16'd1;
        end
      end
    end
  end

  assign m0_count = cnt_q[0];
  assign m1_count = cnt_q[1];
`else
  // Transfer counters are not built in this configuration.
`endif

endmodule
